// File: rtl/gray_conv_pkg.sv
// Shared constants and types for the Gray-to-binary conversion arbiter.
package gray_conv_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/gray_to_bin_core.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR
// of all Gray bits at and above its position.
module gray_to_bin_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary
);

    logic acc;

    always_comb begin
        binary = '0;
        acc    = 1'b0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            acc       = acc ^ gray[k];
            binary[k] = acc;
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary core among N_REQ requesters.
// Optional transfer counter enabled by GRAY_CONV_ARB_CNT_EN.
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_gray,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_binary,
    output logic [ID_W-1:0]        out_id,
    input  logic                   out_ready
`ifdef GRAY_CONV_ARB_CNT_EN
    ,
    input  logic                   cnt_clr,
    output logic [15:0]            conv_count
`endif
);

    out_state_t      state;
    out_state_t      state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] ptr_nxt;
    logic            grant_any;
    logic            slot_free;
    logic            xfer;
    logic [WIDTH-1:0] gray_sel;
    logic [WIDTH-1:0] bin_sel;
    int              idx;

    // Scan offsets high to low so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    assign slot_free = (state == ST_EMPTY) || out_ready;
    assign xfer      = grant_any && slot_free && !rst;
    assign out_valid = (state == ST_FULL);

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign gray_sel = req_gray[grant_id*WIDTH +: WIDTH];

    gray_to_bin_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .gray   (gray_sel),
        .binary (bin_sel)
    );

    assign ptr_nxt = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_EMPTY: begin
                if (xfer) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    state_nxt = ST_FULL;
                end else if (out_ready) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Result and ID hold stale values after the consumer drains them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_binary <= '0;
            out_id     <= '0;
            rr_ptr     <= '0;
        end else if (xfer) begin
            out_binary <= bin_sel;
            out_id     <= grant_id;
            rr_ptr     <= ptr_nxt;
        end
    end

`ifdef GRAY_CONV_ARB_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_count <= '0;
        end else if (cnt_clr) begin
            conv_count <= '0;
        end else if (xfer && conv_count != CNT_MAX) begin
            conv_count <= conv_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Randomized self-checking bench for gray_conv_arbiter against a
// transaction-level reference model.
module tb_gray_conv_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_gray = '0;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_binary;
    logic [1:0]     out_id;
    logic           out_ready = 1'b0;
`ifdef GRAY_CONV_ARB_CNT_EN
    logic           cnt_clr = 1'b0;
    logic [15:0]    conv_count;
`endif

    int n_checks = 0;
    int n_fail = 0;

    bit         m_full;
    logic [W-1:0] m_bin;
    int         m_id;
    int         m_ptr;
    int         m_cnt;

    logic [W-1:0] fair_bin [5];
    int           fair_id [5];
    logic [W-1:0] hold_bin;
    logic [1:0]   hold_id;

    gray_conv_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_binary (out_binary),
        .out_id     (out_id),
        .out_ready  (out_ready)
`ifdef GRAY_CONV_ARB_CNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .conv_count (conv_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Binary value is the prefix XOR of the Gray word from the top down.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int s = 0; s < W; s++) begin
            b = b ^ (g >> s);
        end
        return b;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) begin
                return (ptr + k) % N;
            end
        end
        return -1;
    endfunction

    task automatic reset_model();
        m_full = 1'b0;
        m_bin  = '0;
        m_id   = 0;
        m_ptr  = 0;
        m_cnt  = 0;
    endtask

    task automatic step();
        int g;
        logic [N-1:0] er;
        logic [W-1:0] gw;
        @(negedge clk);
        g  = (!m_full || out_ready) ? pick(req_valid, m_ptr) : -1;
        er = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("out_binary", 32'(out_binary), 32'(m_bin));
        chk("out_id", 32'(out_id), 32'(m_id));
`ifdef GRAY_CONV_ARB_CNT_EN
        chk("conv_count", 32'(conv_count), 32'(m_cnt));
`endif
        if (g >= 0) begin
            gw     = req_gray[g*W +: W];
            m_full = 1'b1;
            m_bin  = g2b(gw);
            m_id   = g;
            m_ptr  = (g + 1) % N;
        end else if (m_full && out_ready) begin
            m_full = 1'b0;
        end
`ifdef GRAY_CONV_ARB_CNT_EN
        if (cnt_clr) begin
            m_cnt = 0;
        end else if (g >= 0 && m_cnt < 65535) begin
            m_cnt = m_cnt + 1;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        fair_bin = '{4'b0000, 4'b0100, 4'b1010, 4'b1111, 4'b0000};
        fair_id  = '{0, 1, 2, 3, 0};
        reset_model();

        rst       = 1'b1;
        req_valid = '1;
        out_ready = 1'b1;
        @(posedge clk);
        #3;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_binary", 32'(out_binary), 32'h0);
        chk("rst_id", 32'(out_id), 32'h0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        req_gray  = 16'b1000_1111_0110_0000;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("fair_valid%0d", i), 32'(out_valid), 32'h1);
            chk($sformatf("fair_bin%0d", i), 32'(out_binary), 32'(fair_bin[i]));
            chk($sformatf("fair_id%0d", i), 32'(out_id), 32'(fair_id[i]));
        end

        req_valid = 4'b0001;
        req_gray  = 16'h000B;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        step();
        chk("single_bin", 32'(out_binary), 32'hD);
        chk("single_id", 32'(out_id), 32'h0);

        req_valid = 4'b1111;
        req_gray  = 16'($urandom);
        out_ready = 1'b0;
        hold_bin  = out_binary;
        hold_id   = out_id;
        repeat (5) begin
            step();
            chk("bp_bin", 32'(out_binary), 32'(hold_bin));
            chk("bp_id", 32'(out_id), 32'(hold_id));
            chk("bp_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_reload_ready", 32'(req_ready != '0), 32'h1);
        step();
        chk("bp_reload_valid", 32'(out_valid), 32'h1);
        chk("bp_reload_id", 32'(out_id), 32'h1);

        req_valid = 4'b0100;
        step();
        req_valid = 4'b0101;
        #1;
        chk("wrap_ready", 32'(req_ready), 32'h1);
        step();
        chk("wrap_id", 32'(out_id), 32'h0);
        #1;
        chk("skip_ready", 32'(req_ready), 32'h4);
        step();
        chk("skip_id", 32'(out_id), 32'h2);

        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_binary", 32'(out_binary), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        reset_model();
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        step();

`ifdef GRAY_CONV_ARB_CNT_EN
        cnt_clr = 1'b1;
        step();
        chk("cnt_clr", 32'(conv_count), 32'h0);
        cnt_clr = 1'b0;
        repeat (20) step();
        chk("cnt_20", 32'(conv_count), 32'd20);
        dut.conv_count = 16'hFFFD;
        m_cnt = 32'hFFFD;
        repeat (5) step();
        chk("cnt_sat", 32'(conv_count), 32'hFFFF);
`endif

        repeat (400) begin
            req_valid = N'($urandom);
            req_gray  = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef GRAY_CONV_ARB_CNT_EN
            cnt_clr = ($urandom_range(0, 31) == 0);
`endif
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
